// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencing FSM for the RV32I core.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> WB and drives every control input
// of the dataflow block. It also counts retired instructions and parks in a
// sticky HALT on an illegal opcode.
//
// All outputs except rs1/rs2/rd come straight from flops. Each flop's next
// value is computed from the state being entered, so strobes are clean
// single-cycle pulses that rise on the edge entering their state.
//
// Selects are decoded from insn on the DECODE->EXEC edge and then held
// through WB. The INSN register loads on insn_clk at the start of DECODE,
// so insn is stable by that edge. Because the selects are already valid
// during EXEC, the ALU compare flags are valid there too. The branch
// decision is sampled on the EXEC->WB edge.
//
// There is no valid/ready handshake in this block; all sequencing is
// implied by the state. dbg_state exposes the current state for checkers.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic        EQ,
  input  logic        LS,
  input  logic        LU,
  output logic        insn_clk,
  output logic        pc_clk,
  output logic        rd_clk,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        alu_sel_a,
  output logic        alu_sel_b,
  output logic        addr_sel,
  output logic [1:0]  rd_sel,
  output logic [2:0]  func,
  output logic        sub_sra,
  output logic [2:0]  mem_size,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        mem_we,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;

  state_t state_q, state_d;

  logic        insn_clk_q, insn_clk_d;
  logic        pc_clk_q, pc_clk_d;
  logic        rd_clk_q, rd_clk_d;
  logic        pc_next_sel_q, pc_next_sel_d;
  logic        pc_alu_sel_q, pc_alu_sel_d;
  logic        alu_sel_a_q, alu_sel_a_d;
  logic        alu_sel_b_q, alu_sel_b_d;
  logic        addr_sel_q, addr_sel_d;
  logic [1:0]  rd_sel_q, rd_sel_d;
  logic [2:0]  func_q, func_d;
  logic        sub_sra_q, sub_sra_d;
  logic [2:0]  mem_size_q, mem_size_d;
  logic        mem_we_q, mem_we_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;

  // Decoded fields and select values for the instruction currently in insn
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch;
  logic       writes_rd, insn_bad, taken;
  logic       dec_pc_next_sel, dec_alu_sel_a, dec_alu_sel_b, dec_sub_sra;
  logic [1:0] dec_rd_sel;
  logic [2:0] dec_func;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign rd     = insn[11:7];

  // Opcode decode: select values, opcode class and legality
  always_comb begin
    dec_pc_next_sel = 1'b0;
    dec_alu_sel_a   = 1'b0;
    dec_alu_sel_b   = 1'b0;
    dec_sub_sra     = 1'b0;
    dec_rd_sel      = 2'd0;
    dec_func        = 3'b000;
    is_load         = 1'b0;
    is_store        = 1'b0;
    is_branch       = 1'b0;
    writes_rd       = 1'b0;
    insn_bad        = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_func    = funct3;
        dec_sub_sra = insn[30];
        dec_rd_sel  = 2'd2;
        writes_rd   = 1'b1;
      end
      OPC_OPIMM: begin
        dec_func      = funct3;
        dec_alu_sel_b = 1'b1;
        dec_sub_sra   = (funct3 == 3'b101) ? insn[30] : 1'b0;
        dec_rd_sel    = 2'd2;
        writes_rd     = 1'b1;
      end
      OPC_LUI: begin
        dec_rd_sel = 2'd1;
        writes_rd  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_alu_sel_a = 1'b1;
        dec_alu_sel_b = 1'b1;
        dec_rd_sel    = 2'd2;
        writes_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec_alu_sel_a   = 1'b1;
        dec_alu_sel_b   = 1'b1;
        dec_pc_next_sel = 1'b1;
        dec_rd_sel      = 2'd3;
        writes_rd       = 1'b1;
      end
      OPC_JALR: begin
        dec_alu_sel_b   = 1'b1;
        dec_pc_next_sel = 1'b1;
        dec_rd_sel      = 2'd3;
        writes_rd       = 1'b1;
      end
      OPC_BRANCH: begin
        dec_sub_sra = 1'b1;
        is_branch   = 1'b1;
        insn_bad    = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec_alu_sel_b = 1'b1;
        dec_rd_sel    = 2'd0;
        is_load       = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        dec_alu_sel_b = 1'b1;
        is_store      = 1'b1;
      end
      OPC_FENCE: begin
      end
      // SYSTEM (ECALL/EBREAK) and every unknown opcode stop the core
      default: insn_bad = 1'b1;
    endcase
  end

  // Branch decision from the ALU compare flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = EQ;
      3'b001:  taken = ~EQ;
      3'b100:  taken = LS;
      3'b101:  taken = ~LS;
      3'b110:  taken = LU;
      3'b111:  taken = ~LU;
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (insn_bad)                  state_d = S_HALT;
        else if (is_load || is_store)  state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output flop next values, chosen by the state being entered
  always_comb begin
    insn_clk_d    = 1'b0;
    pc_clk_d      = 1'b0;
    rd_clk_d      = 1'b0;
    mem_we_d      = 1'b0;
    pc_next_sel_d = pc_next_sel_q;
    pc_alu_sel_d  = pc_alu_sel_q;
    alu_sel_a_d   = alu_sel_a_q;
    alu_sel_b_d   = alu_sel_b_q;
    addr_sel_d    = addr_sel_q;
    rd_sel_d      = rd_sel_q;
    func_d        = func_q;
    sub_sra_d     = sub_sra_q;
    mem_size_d    = mem_size_q;
    illegal_d     = illegal_q;
    instret_d     = instret_q;
    case (state_d)
      S_FETCH, S_HALT: begin
        pc_next_sel_d = 1'b0;
        pc_alu_sel_d  = 1'b0;
        alu_sel_a_d   = 1'b0;
        alu_sel_b_d   = 1'b0;
        addr_sel_d    = 1'b0;
        rd_sel_d      = 2'd0;
        func_d        = 3'b000;
        sub_sra_d     = 1'b0;
        mem_size_d    = 3'b000;
        if (state_d == S_HALT) illegal_d = 1'b1;
      end
      S_DECODE: insn_clk_d = 1'b1;
      S_EXEC: begin
        pc_next_sel_d = dec_pc_next_sel;
        pc_alu_sel_d  = 1'b0;
        alu_sel_a_d   = dec_alu_sel_a;
        alu_sel_b_d   = dec_alu_sel_b;
        addr_sel_d    = 1'b0;
        rd_sel_d      = dec_rd_sel;
        func_d        = dec_func;
        sub_sra_d     = dec_sub_sra;
        mem_size_d    = funct3;
      end
      S_MEM: begin
        addr_sel_d = 1'b1;
        mem_we_d   = is_store;
      end
      S_WB: begin
        pc_clk_d  = 1'b1;
        rd_clk_d  = writes_rd && (rd != 5'd0);
        if (is_branch) pc_alu_sel_d = taken;
        instret_d = instret_q + 32'd1;
      end
      default: ;
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      insn_clk_q    <= 1'b0;
      pc_clk_q      <= 1'b0;
      rd_clk_q      <= 1'b0;
      pc_next_sel_q <= 1'b0;
      pc_alu_sel_q  <= 1'b0;
      alu_sel_a_q   <= 1'b0;
      alu_sel_b_q   <= 1'b0;
      addr_sel_q    <= 1'b0;
      rd_sel_q      <= 2'd0;
      func_q        <= 3'b000;
      sub_sra_q     <= 1'b0;
      mem_size_q    <= 3'b000;
      mem_we_q      <= 1'b0;
      illegal_q     <= 1'b0;
      instret_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      insn_clk_q    <= insn_clk_d;
      pc_clk_q      <= pc_clk_d;
      rd_clk_q      <= rd_clk_d;
      pc_next_sel_q <= pc_next_sel_d;
      pc_alu_sel_q  <= pc_alu_sel_d;
      alu_sel_a_q   <= alu_sel_a_d;
      alu_sel_b_q   <= alu_sel_b_d;
      addr_sel_q    <= addr_sel_d;
      rd_sel_q      <= rd_sel_d;
      func_q        <= func_d;
      sub_sra_q     <= sub_sra_d;
      mem_size_q    <= mem_size_d;
      mem_we_q      <= mem_we_d;
      illegal_q     <= illegal_d;
      instret_q     <= instret_d;
    end
  end

  assign insn_clk    = insn_clk_q;
  assign pc_clk      = pc_clk_q;
  assign rd_clk      = rd_clk_q;
  assign pc_next_sel = pc_next_sel_q;
  assign pc_alu_sel  = pc_alu_sel_q;
  assign alu_sel_a   = alu_sel_a_q;
  assign alu_sel_b   = alu_sel_b_q;
  assign addr_sel    = addr_sel_q;
  assign rd_sel      = rd_sel_q;
  assign func        = func_q;
  assign sub_sra     = sub_sra_q;
  assign mem_size    = mem_size_q;
  assign mem_we      = mem_we_q;
  assign illegal     = illegal_q;
  assign instret     = instret_q;
  assign dbg_state   = state_q;

endmodule
